// File: rtl/lm_sm_expander_pkg.sv
// Shared definitions for the LM/SM expander: opcodes, bubble encoding,
// FSM state type and the micro-op builder.
package lm_sm_expander_pkg;

   localparam logic [3:0]  OP_LW  = 4'b0100;
   localparam logic [3:0]  OP_SW  = 4'b0101;
   localparam logic [3:0]  OP_LM  = 4'b0110;
   localparam logic [3:0]  OP_SM  = 4'b0111;
   localparam logic [15:0] NOP_IR = 16'hF000;

   typedef enum logic {IDLE, EXPAND} state_t;

   // Single-register LW/SW whose offset equals the register number, so
   // memory word i pairs with register i.
   function automatic logic [15:0] micro_op(input logic       is_sm,
                                            input logic [2:0] rt,
                                            input logic [2:0] base);
      micro_op = {(is_sm ? OP_SW : OP_LW), rt, base, 3'b000, rt};
   endfunction

endpackage

// File: rtl/lm_sm_expander_lsb_priority_enc8.sv
// Lowest-set-bit priority encoder for an 8-bit register mask.
module lsb_priority_enc8 (
   input  logic [7:0] mask,
   output logic [2:0] idx,
   output logic       none
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx  = 3'd0;
      none = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) begin
            idx  = 3'(i);
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/lm_sm_expander.sv
// Pipe-2 register stage that expands LM/SM into single-register LW/SW
// micro-ops and holds fetch while an expansion is in progress.
// Optional build macro: LMSM_DEFER_BASE_EN -- an LM that loads its own base
// register issues that load last so every address uses the original base.
module lm_sm_expander #(
   parameter logic [15:0] NOP_IR = 16'hF000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] IRIn,
   input  logic [15:0] PCIn,
   input  logic [15:0] incPCIn,
   input  logic        stall,
   input  logic        flush,
   output logic [15:0] pr2_IR,
   output logic [15:0] pr2_PC,
   output logic [15:0] pr2_incPC,
   output logic        pr2_valid,
   output logic        PCWrite
);

   import lm_sm_expander_pkg::*;

   state_t      state, state_nxt;
   logic [7:0]  rem_mask, rem_mask_nxt;
   logic [2:0]  base_r, base_nxt;
   logic        is_sm_r, is_sm_nxt;
   logic        defer_r, defer_nxt;
   logic [15:0] pc_lat, pc_lat_nxt, inc_lat, inc_lat_nxt;
   logic [15:0] ir_nxt, pc_nxt, inc_nxt;
   logic        valid_nxt;

   logic        in_lmsm, in_sm;
   logic [2:0]  in_base;
   logic [7:0]  in_mask, first_mask;
   logic        first_defer;
   logic [7:0]  enc_in, cleared;
   logic [2:0]  enc_idx;
   logic        enc_none, last_op, pending;
   logic        unused_ir8;

   assign in_sm      = (IRIn[15:12] == OP_SM);
   assign in_lmsm    = (IRIn[15:12] == OP_LM) || in_sm;
   assign in_base    = IRIn[11:9];
   assign in_mask    = IRIn[7:0];
   assign unused_ir8 = IRIn[8];

   // Mask handled up front; with deferral the LM base load is set aside.
   always_comb begin
      first_mask  = in_mask;
      first_defer = 1'b0;
`ifdef LMSM_DEFER_BASE_EN
      if (!in_sm) begin
         first_mask  = in_mask & ~(8'd1 << in_base);
         first_defer = in_mask[in_base];
      end
`endif
   end

   assign enc_in = (state == EXPAND) ? rem_mask : first_mask;

   lsb_priority_enc8 u_enc (
      .mask (enc_in),
      .idx  (enc_idx),
      .none (enc_none)
   );

   assign cleared = enc_in & ~(8'd1 << enc_idx);
   assign last_op = enc_none ? 1'b1 : ((cleared == 8'd0) && !defer_r);
   assign pending = (state == EXPAND) && !last_op;
   // Fetch is released on the edge that issues the final micro-op.
   assign PCWrite = flush || (!stall && !pending);

   // Next-state and next-output selection; defaults hold everything.
   always_comb begin
      state_nxt    = state;
      rem_mask_nxt = rem_mask;
      base_nxt     = base_r;
      is_sm_nxt    = is_sm_r;
      defer_nxt    = defer_r;
      pc_lat_nxt   = pc_lat;
      inc_lat_nxt  = inc_lat;
      ir_nxt       = pr2_IR;
      pc_nxt       = pr2_PC;
      inc_nxt      = pr2_incPC;
      valid_nxt    = pr2_valid;
      if (flush) begin
         ir_nxt       = NOP_IR;
         valid_nxt    = 1'b0;
         state_nxt    = IDLE;
         rem_mask_nxt = 8'd0;
         defer_nxt    = 1'b0;
      end else if (!stall) begin
         case (state)
            IDLE: begin
               pc_nxt  = PCIn;
               inc_nxt = incPCIn;
               if (!in_lmsm) begin
                  ir_nxt    = IRIn;
                  valid_nxt = 1'b1;
               end else begin
                  base_nxt    = in_base;
                  is_sm_nxt   = in_sm;
                  pc_lat_nxt  = PCIn;
                  inc_lat_nxt = incPCIn;
                  if (enc_none && !first_defer) begin
                     ir_nxt    = NOP_IR;
                     valid_nxt = 1'b0;
                  end else if (!enc_none) begin
                     ir_nxt       = micro_op(in_sm, enc_idx, in_base);
                     valid_nxt    = 1'b1;
                     rem_mask_nxt = cleared;
                     defer_nxt    = first_defer;
                     state_nxt    = ((cleared != 8'd0) || first_defer) ? EXPAND : IDLE;
                  end else begin
                     ir_nxt       = micro_op(in_sm, in_base, in_base);
                     valid_nxt    = 1'b1;
                     rem_mask_nxt = 8'd0;
                     defer_nxt    = 1'b0;
                  end
               end
            end
            EXPAND: begin
               pc_nxt    = pc_lat;
               inc_nxt   = inc_lat;
               valid_nxt = 1'b1;
               if (!enc_none) begin
                  ir_nxt       = micro_op(is_sm_r, enc_idx, base_r);
                  rem_mask_nxt = cleared;
               end else begin
                  ir_nxt    = micro_op(is_sm_r, base_r, base_r);
                  defer_nxt = 1'b0;
               end
               state_nxt = last_op ? IDLE : EXPAND;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // pipe-2 register and expansion control state
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rem_mask  <= 8'd0;
         defer_r   <= 1'b0;
         pr2_IR    <= NOP_IR;
         pr2_PC    <= 16'd0;
         pr2_incPC <= 16'd0;
         pr2_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         rem_mask  <= rem_mask_nxt;
         defer_r   <= defer_nxt;
         pr2_IR    <= ir_nxt;
         pr2_PC    <= pc_nxt;
         pr2_incPC <= inc_nxt;
         pr2_valid <= valid_nxt;
      end
   end

   // Latched LM/SM fields; only read while EXPAND, so no reset needed.
   always_ff @(posedge clk) begin
      base_r  <= base_nxt;
      is_sm_r <= is_sm_nxt;
      pc_lat  <= pc_lat_nxt;
      inc_lat <= inc_lat_nxt;
   end

endmodule

// File: tb/tb_lm_sm_expander.sv
// Scoreboard bench for lm_sm_expander: stimulus pushes the expected pipe-2
// contents for each edge, a monitor pops and compares after every edge.
module tb_lm_sm_expander;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [15:0] IRIn, PCIn, incPCIn;
   logic [15:0] pr2_IR, pr2_PC, pr2_incPC;
   logic        pr2_valid, PCWrite;

   typedef struct packed {
      logic [15:0] ir;
      logic [15:0] pc;
      logic [15:0] inc;
      logic        v;
      logic        chk_pc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   mon_idx = 0;

   localparam logic [1:0] NA = 2'd2;
   localparam logic [1:0] HI = 2'd1;
   localparam logic [1:0] LO = 2'd0;

`ifdef LMSM_DEFER_BASE_EN
   localparam logic [15:0] LM_OP2 = 16'h4884;
   localparam logic [15:0] LM_OP3 = 16'h4482;
`else
   localparam logic [15:0] LM_OP2 = 16'h4482;
   localparam logic [15:0] LM_OP3 = 16'h4884;
`endif

   lm_sm_expander #(.NOP_IR(16'hF000)) dut (
      .clk       (clk),
      .reset     (reset),
      .IRIn      (IRIn),
      .PCIn      (PCIn),
      .incPCIn   (incPCIn),
      .stall     (stall),
      .flush     (flush),
      .pr2_IR    (pr2_IR),
      .pr2_PC    (pr2_PC),
      .pr2_incPC (pr2_incPC),
      .pr2_valid (pr2_valid),
      .PCWrite   (PCWrite)
   );

   always #5 clk = ~clk;

   // Monitor: one expected entry per edge
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (pr2_IR !== e.ir || pr2_valid !== e.v) begin
            errors++;
            $display("FAIL out_ir[%0d]: got IR=%h valid=%b, expected IR=%h valid=%b",
                     mon_idx, pr2_IR, pr2_valid, e.ir, e.v);
         end
         if (e.chk_pc) begin
            checks++;
            if (pr2_PC !== e.pc || pr2_incPC !== e.inc) begin
               errors++;
               $display("FAIL out_pc[%0d]: got PC=%h incPC=%h, expected PC=%h incPC=%h",
                        mon_idx, pr2_PC, pr2_incPC, e.pc, e.inc);
            end
         end
         mon_idx++;
      end
   end

   task automatic cyc(input logic rst, input logic [15:0] ir, pc, inc,
                      input logic st, fl,
                      input logic [15:0] e_ir, e_pc, e_inc,
                      input logic e_v, e_chkpc, input logic [1:0] e_pcw,
                      input string name);
      exp_t e;
      @(negedge clk);
      reset   = rst;
      IRIn    = ir;
      PCIn    = pc;
      incPCIn = inc;
      stall   = st;
      flush   = fl;
      #1;
      if (e_pcw != NA) begin
         checks++;
         if (PCWrite !== e_pcw[0]) begin
            errors++;
            $display("FAIL pcwrite_%s: got %b, expected %b", name, PCWrite, e_pcw[0]);
         end
      end
      e = '{e_ir, e_pc, e_inc, e_v, e_chkpc};
      sb.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      IRIn = 16'h0000; PCIn = 16'h0000; incPCIn = 16'h0000;

      // reset for two cycles
      cyc(1, 16'h0000, 16'd0, 16'd0, 0, 0, 16'hF000, 16'd0, 16'd0, 0, 1, NA, "rst0");
      cyc(1, 16'h0000, 16'd0, 16'd0, 0, 0, 16'hF000, 16'd0, 16'd0, 0, 1, NA, "rst1");

      // plain instruction passes through
      cyc(0, 16'h0250, 16'd5, 16'd6, 0, 0, 16'h0250, 16'd5, 16'd6, 1, 1, HI, "add");

      // LM R2, mask 00010110
      cyc(0, 16'h6416, 16'd10, 16'd11, 0, 0, 16'h4281, 16'd10, 16'd11, 1, 1, HI, "lm_a");
      cyc(0, 16'h1234, 16'd11, 16'd12, 0, 0, LM_OP2,   16'd10, 16'd11, 1, 1, LO, "lm_b");
      cyc(0, 16'h1234, 16'd11, 16'd12, 0, 0, LM_OP3,   16'd10, 16'd11, 1, 1, HI, "lm_c");
      cyc(0, 16'h1234, 16'd11, 16'd12, 0, 0, 16'h1234, 16'd11, 16'd12, 1, 1, HI, "after_lm");

      // SM with empty mask: one bubble, fetch never held
      cyc(0, 16'h7600, 16'd20, 16'd21, 0, 0, 16'hF000, 16'd0, 16'd0, 0, 0, HI, "sm0");
      cyc(0, 16'h2345, 16'd21, 16'd22, 0, 0, 16'h2345, 16'd21, 16'd22, 1, 1, HI, "after_sm0");

      // SM R0, mask FF with a 3-cycle stall after the second micro-op
      cyc(0, 16'h70FF, 16'd30, 16'd31, 0, 0, 16'h5000, 16'd30, 16'd31, 1, 1, HI, "smff0");
      cyc(0, 16'h3000, 16'd31, 16'd32, 0, 0, 16'h5201, 16'd30, 16'd31, 1, 1, LO, "smff1");
      for (int s = 0; s < 3; s++)
         cyc(0, 16'h3000, 16'd31, 16'd32, 1, 0, 16'h5201, 16'd30, 16'd31, 1, 1, LO, "smff_stall");
      for (int i = 2; i < 8; i++)
         cyc(0, 16'h3000, 16'd31, 16'd32, 0, 0,
             16'h5000 | (16'(i) << 9) | 16'(i), 16'd30, 16'd31, 1, 1,
             (i == 7) ? HI : LO, "smff_n");
      cyc(0, 16'h3000, 16'd31, 16'd32, 0, 0, 16'h3000, 16'd31, 16'd32, 1, 1, HI, "after_smff");

      // LM R1, mask F0, flushed on the second micro-op cycle
      cyc(0, 16'h62F0, 16'd40, 16'd41, 0, 0, 16'h4844, 16'd40, 16'd41, 1, 1, HI, "lmf0");
      cyc(0, 16'h1111, 16'd41, 16'd42, 0, 1, 16'hF000, 16'd0, 16'd0, 0, 0, HI, "lmf_flush");
      cyc(0, 16'h1111, 16'd50, 16'd51, 0, 0, 16'h1111, 16'd50, 16'd51, 1, 1, HI, "after_flush");
      cyc(0, 16'h2222, 16'd51, 16'd52, 0, 0, 16'h2222, 16'd51, 16'd52, 1, 1, HI, "idle_tail");

      // drain the scoreboard with a bounded wait
      for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
